// File: rtl/instr_dispatch_pkg.sv
// Shared types and configuration for the instruction dispatch stage.
package instr_dispatch_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int POP_LATENCY = 1;
  localparam int HOLD_DEPTH  = 3 * FETCH_WIDTH;
  localparam int CNT_W       = $clog2(HOLD_DEPTH + 1);
  localparam int ISSUE_CNT_W = $clog2(FETCH_WIDTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  uop;
    logic        valid;
  } decoded_instr_t;

endpackage

// File: rtl/instr_hold_queue.sv
// In-order compacting shift queue: drops an accepted prefix and appends the
// valid subset of incoming entries behind the survivors in one cycle.
module instr_hold_queue #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 6,
  parameter int IN_CNT  = 2,
  parameter int OUT_CNT = 2,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int POP_W   = $clog2(OUT_CNT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic [WIDTH-1:0]  in_data_i [IN_CNT],
  input  logic [IN_CNT-1:0] in_valid_i,
  input  logic [POP_W-1:0]  pop_cnt_i,
  output logic [WIDTH-1:0]  out_data_o [OUT_CNT],
  output logic [CNT_W-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q   [DEPTH];
  logic [WIDTH-1:0] mem_d   [DEPTH];
  logic [WIDTH-1:0] shifted [DEPTH];
  logic [CNT_W-1:0] count_q, count_d, wr_idx;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
    logic [WIDTH-1:0] cand [OUT_CNT+1];
    for (genvar gs = 0; gs <= OUT_CNT; gs++) begin : g_cand
      if (gi + gs < DEPTH) begin : g_in
        assign cand[gs] = mem_q[gi+gs];
      end else begin : g_past_end
        assign cand[gs] = mem_q[gi];
      end
    end
    assign shifted[gi] = (pop_cnt_i <= POP_W'(OUT_CNT)) ? cand[pop_cnt_i] : mem_q[gi];
  end

  // Arrivals land behind the surviving entries; invalid slots are skipped.
  always_comb begin
    mem_d  = shifted;
    wr_idx = count_q - CNT_W'(pop_cnt_i);
    for (int j = 0; j < IN_CNT; j++) begin
      if (in_valid_i[j]) begin
        if (wr_idx < CNT_W'(DEPTH)) mem_d[wr_idx] = in_data_i[j];
        wr_idx = wr_idx + CNT_W'(1);
      end
    end
    count_d = clr_i ? '0 : wr_idx;
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  for (genvar gi = 0; gi < OUT_CNT; gi++) begin : g_out
    assign out_data_o[gi] = mem_q[gi];
  end

  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_d <= CNT_W'(DEPTH));

endmodule

// File: rtl/instr_dispatch.sv
// Dispatch stage: pops decoded-instruction pairs from the buffer and presents
// the oldest held instructions to rename/issue in program order.
module instr_dispatch
  import instr_dispatch_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic                   o_dequeue,
  input  decoded_instr_t         i_instrs [0:FETCH_WIDTH-1],
  input  logic                   i_flush,
  output decoded_instr_t         o_issue [0:FETCH_WIDTH-1],
  input  logic [ISSUE_CNT_W-1:0] i_issue_cnt,
  output logic                   o_empty
);

  localparam int W = $bits(decoded_instr_t);

  logic                   inflight_q, inflight_d;
  logic                   capture;
  logic [FETCH_WIDTH-1:0] resp_mask, arr_valid, mask_inc;
  logic [W-1:0]           arr_data  [FETCH_WIDTH];
  logic [W-1:0]           head_data [FETCH_WIDTH];
  logic [CNT_W-1:0]       count;
  logic [ISSUE_CNT_W-1:0] pop_cnt;

  // A pop is only issued if the queue can absorb it plus any pair still in flight.
  assign o_dequeue = i_rst_n && !i_flush &&
    (int'(count) + (inflight_q ? POP_LATENCY * FETCH_WIDTH : 0) <= HOLD_DEPTH - FETCH_WIDTH);
  assign inflight_d = o_dequeue;
  assign capture    = inflight_q && !i_flush;
  assign pop_cnt    = i_flush ? '0 : i_issue_cnt;
  assign o_empty    = (count == '0) && !inflight_q;
  assign mask_inc   = resp_mask + FETCH_WIDTH'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) inflight_q <= 1'b0;
    else          inflight_q <= inflight_d;
  end

  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
    assign resp_mask[gi] = i_instrs[gi].valid;
    assign arr_valid[gi] = capture && i_instrs[gi].valid;
    assign arr_data[gi]  = i_instrs[gi];
    assign o_issue[gi]   = {head_data[gi][W-1:1], (count > CNT_W'(gi))};
  end

  instr_hold_queue #(
    .WIDTH   (W),
    .DEPTH   (HOLD_DEPTH),
    .IN_CNT  (FETCH_WIDTH),
    .OUT_CNT (FETCH_WIDTH)
  ) u_hold (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .clr_i      (i_flush),
    .in_data_i  (arr_data),
    .in_valid_i (arr_valid),
    .pop_cnt_i  (pop_cnt),
    .out_data_o (head_data),
    .count_o    (count)
  );

  a_issue_cnt_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !i_flush |-> (int'(i_issue_cnt) <= FETCH_WIDTH && int'(i_issue_cnt) <= int'(count)));

  a_resp_prefix: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    capture |-> ((resp_mask & mask_inc) == '0));

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: directed table plus randomized
// traffic against a queue-based reference model.
module tb_instr_dispatch;
  import instr_dispatch_pkg::*;

  logic                   i_clk, i_rst_n, o_dequeue, i_flush, o_empty;
  decoded_instr_t         i_instrs [0:FETCH_WIDTH-1];
  decoded_instr_t         o_issue  [0:FETCH_WIDTH-1];
  logic [ISSUE_CNT_W-1:0] i_issue_cnt;

  instr_dispatch dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_dequeue   (o_dequeue),
    .i_instrs    (i_instrs),
    .i_flush     (i_flush),
    .o_issue     (o_issue),
    .i_issue_cnt (i_issue_cnt),
    .o_empty     (o_empty)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    bit       flush;
    int       issue;
    bit [1:0] mask;
    bit       exp_deq;
    bit [1:0] exp_vld;
    bit       exp_empty;
  } vec_t;

  vec_t           tab[$];
  decoded_instr_t ref_q[$];
  bit             pend;
  int             n_vec = 0;
  int             n_err = 0;
  int             next_tag = 1;

  function automatic void add(input bit f, input int iss, input bit [1:0] m,
                              input bit d, input bit [1:0] v, input bit e);
    vec_t r;
    r.flush = f; r.issue = iss; r.mask = m;
    r.exp_deq = d; r.exp_vld = v; r.exp_empty = e;
    tab.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic run_cycle(input bit flush, input int issue, input bit [1:0] mask,
                           input bit use_tab, input bit t_deq, input bit [1:0] t_vld,
                           input bit t_empty, input int row);
    int             n_iss, occ;
    bit             exp_deq;
    decoded_instr_t resp [FETCH_WIDTH];
    occ   = ref_q.size();
    n_iss = issue;
    if (n_iss > occ) n_iss = occ;
    if (n_iss > FETCH_WIDTH) n_iss = FETCH_WIDTH;
    i_flush     = flush;
    i_issue_cnt = ISSUE_CNT_W'(n_iss);
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      resp[k].pc    = 32'(next_tag);
      resp[k].uop   = 8'($urandom);
      resp[k].valid = mask[k];
      i_instrs[k]   = resp[k];
      next_tag++;
    end
    #1;
    exp_deq = !flush && (occ + (pend ? FETCH_WIDTH : 0) <= HOLD_DEPTH - FETCH_WIDTH);
    chk($sformatf("dequeue t=%0t", $time), 64'(o_dequeue), 64'(exp_deq));
    chk($sformatf("empty t=%0t", $time), 64'(o_empty), 64'(occ == 0 && !pend));
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (k < occ) chk($sformatf("issue[%0d] t=%0t", k, $time), 64'(o_issue[k]), 64'(ref_q[k]));
      else         chk($sformatf("issue_valid[%0d] t=%0t", k, $time), 64'(o_issue[k].valid), 64'(0));
    end
    if (use_tab) begin
      chk($sformatf("row%0d_dequeue", row), 64'(o_dequeue), 64'(t_deq));
      chk($sformatf("row%0d_valid", row), 64'({o_issue[1].valid, o_issue[0].valid}), 64'(t_vld));
      chk($sformatf("row%0d_empty", row), 64'(o_empty), 64'(t_empty));
    end
    $display("cycle t=%0t flush=%0d issue=%0d mask=%b deq=%0d empty=%0d held=%0d",
             $time, flush, n_iss, mask, o_dequeue, o_empty, occ);
    @(posedge i_clk);
    if (flush) begin
      ref_q.delete();
      pend = 1'b0;
    end else begin
      repeat (n_iss) void'(ref_q.pop_front());
      if (pend) begin
        for (int k = 0; k < FETCH_WIDTH; k++)
          if (mask[k]) ref_q.push_back(resp[k]);
      end
      pend = exp_deq;
    end
    #1;
  endtask

  initial begin
    bit [1:0] masks [3];
    masks[0] = 2'b00; masks[1] = 2'b01; masks[2] = 2'b11;
    i_rst_n = 1'b0; i_flush = 1'b0; i_issue_cnt = '0; pend = 1'b0;
    for (int k = 0; k < FETCH_WIDTH; k++) i_instrs[k] = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_dequeue", 64'(o_dequeue), 64'(0));
    chk("rst_valid", 64'({o_issue[1].valid, o_issue[0].valid}), 64'(0));
    chk("rst_empty", 64'(o_empty), 64'(1));
    i_rst_n = 1'b1;

    // idle buffer, then continuous pairs
    add(0, 0, 2'b00, 1, 2'b00, 1);
    add(0, 0, 2'b00, 1, 2'b00, 0);
    add(0, 0, 2'b00, 1, 2'b00, 0);
    add(0, 0, 2'b11, 1, 2'b00, 0);
    add(0, 2, 2'b11, 1, 2'b11, 0);
    add(0, 2, 2'b11, 1, 2'b11, 0);
    add(0, 2, 2'b11, 1, 2'b11, 0);
    // backpressure to full, then drain one at a time
    add(0, 0, 2'b11, 1, 2'b11, 0);
    add(0, 0, 2'b11, 0, 2'b11, 0);
    add(0, 0, 2'b11, 0, 2'b11, 0);
    add(0, 0, 2'b11, 0, 2'b11, 0);
    add(0, 0, 2'b11, 0, 2'b11, 0);
    add(0, 0, 2'b11, 0, 2'b11, 0);
    add(0, 1, 2'b11, 0, 2'b11, 0);
    add(0, 1, 2'b11, 0, 2'b11, 0);
    add(0, 0, 2'b11, 1, 2'b11, 0);
    add(0, 2, 2'b11, 0, 2'b11, 0);
    add(0, 2, 2'b11, 1, 2'b11, 0);
    // single-slot responses and partial accept
    add(0, 2, 2'b01, 1, 2'b11, 0);
    add(0, 0, 2'b01, 1, 2'b01, 0);
    add(0, 1, 2'b11, 1, 2'b11, 0);
    add(0, 1, 2'b00, 0, 2'b11, 0);
    add(0, 0, 2'b00, 1, 2'b11, 0);
    add(0, 0, 2'b11, 1, 2'b11, 0);
    // flush with four held and a pair in flight
    add(1, 0, 2'b11, 0, 2'b11, 0);
    add(0, 0, 2'b11, 1, 2'b00, 1);
    add(0, 0, 2'b11, 1, 2'b00, 0);
    add(0, 2, 2'b00, 1, 2'b11, 0);
    add(0, 0, 2'b00, 1, 2'b00, 0);

    foreach (tab[i])
      run_cycle(tab[i].flush, tab[i].issue, tab[i].mask, 1'b1,
                tab[i].exp_deq, tab[i].exp_vld, tab[i].exp_empty, i);

    // asynchronous reset mid-operation
    repeat (3) run_cycle(1'b0, 0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 0);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_dequeue", 64'(o_dequeue), 64'(0));
    chk("midrst_valid", 64'({o_issue[1].valid, o_issue[0].valid}), 64'(0));
    chk("midrst_empty", 64'(o_empty), 64'(1));
    ref_q.delete();
    pend = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    run_cycle(1'b0, 0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b1, 100);
    run_cycle(1'b0, 0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 101);

    for (int n = 0; n < 400; n++) begin
      run_cycle($urandom_range(0, 19) == 0, int'($urandom_range(0, 2)),
                masks[$urandom_range(0, 2)], 1'b0, 1'b0, 2'b00, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
